// File: rtl/instr_encoder.sv
// RV32I field-bundle to instruction-word encoder with a 2-entry output FIFO and address tagging.
// Define ENC_RANGE_CHECK_EN to flag immediates that do not fit their format.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [31:0] enc_word;
  logic        fmt_err;
  logic        rng_err;
  logic        enc_err;

  logic [31:0] mem_word [2];
  logic        mem_err  [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic [31:0] addr;

  logic        push;
  logic        pop;

  always_comb begin
    enc_word = NOP_WORD;
    fmt_err  = 1'b0;
    case (in_fmt)
      FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: enc_word = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                         in_rd, in_opcode};
      default: begin
        enc_word = NOP_WORD;
        fmt_err  = 1'b1;
      end
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // An immediate fits N-bit signed when every bit above N-1 equals the sign bit.
  always_comb begin
    rng_err = 1'b0;
    case (in_fmt)
      FMT_I, FMT_S: rng_err = (in_imm[31:11] != {21{in_imm[11]}});
      FMT_B:        rng_err = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
      FMT_J:        rng_err = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
      FMT_U:        rng_err = (in_imm[11:0] != 12'd0);
      default:      rng_err = 1'b0;
    endcase
  end
`else
  assign rng_err = 1'b0;
`endif

  assign enc_err = fmt_err | rng_err;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_instr = mem_word[head];
  assign out_err   = mem_err[head];
  assign out_addr  = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_word[i] <= '0;
        mem_err[i]  <= 1'b0;
      end
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= '0;
      addr  <= BASE_ADDR;
    end else if (clr) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_word[i] <= '0;
        mem_err[i]  <= 1'b0;
      end
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= '0;
      addr  <= BASE_ADDR;
    end else begin
      if (push) begin
        mem_word[tail] <= enc_word;
        mem_err[tail]  <= enc_err;
        tail           <= ~tail;
      end
      if (pop) begin
        head <= ~head;
        addr <= addr + ADDR_STEP;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
